// File: rtl/regfile_arb_pkg.sv
// Shared types and sizes for the register-file debug arbiter.
// Holds the arbiter state encoding, the register-file geometry and a
// helper that sizes the debug wait counter.
package regfile_arb_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STALL  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } arb_state_e;

  // Bits needed to count 0..max_wait, never less than one bit.
  function automatic int ctr_width(input int max_wait);
    if (max_wait < 1) return 1;
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/regfile_arb_wait_ctr.sv
// Saturating wait counter for the debug arbiter.
// Counts core write cycles seen while a debug request waits and flags when
// the count has reached MAX_WAIT. The counter only exists when
// REGFILE_ARB_TIMEOUT_EN is defined; otherwise the flag is tied low so a
// waiting request never forces a stall.
module regfile_arb_wait_ctr
  import regfile_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic reset_,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

`ifdef REGFILE_ARB_TIMEOUT_EN
  localparam int CTR_W = ctr_width(MAX_WAIT);
  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(MAX_WAIT);

  logic [CTR_W-1:0] r_count;

  // Clear takes priority; increments stop once the limit is reached.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + CTR_W'(1);
    end
  end

  assign o_at_limit = (r_count == LIMIT);
`else
  // No timeout: nothing to count, the request waits for a write-free cycle.
  logic w_unused_inputs;
  assign w_unused_inputs = ^{clk, reset_, i_clr, i_inc, (MAX_WAIT < 0)};
  assign o_at_limit      = 1'b0;
`endif

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Register-file debug arbiter.
// Shares the register file write port and SR2 read port between the core
// datapath and a debug host. Core traffic passes through except during the
// single ACCESS cycle of a debug transaction, when the host owns the ports.
// The host talks over a four-phase req/ack handshake.
// Optional feature: define REGFILE_ARB_TIMEOUT_EN to force the stall after
// MAX_WAIT busy core cycles instead of waiting for a write-free cycle.
module regfile_debug_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  core_ld_reg,
  input  logic [REG_ADDR_W-1:0] core_dr,
  input  logic [REG_DATA_W-1:0] core_bus,
  input  logic [REG_ADDR_W-1:0] core_sr2_sel,
  output logic                  rf_ld_reg,
  output logic [REG_ADDR_W-1:0] rf_dr,
  output logic [REG_DATA_W-1:0] rf_bus,
  output logic [REG_ADDR_W-1:0] rf_sr2_sel,
  input  logic [REG_DATA_W-1:0] rf_sr2,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [REG_DATA_W-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [REG_DATA_W-1:0] dbg_rdata
);

  arb_state_e            r_state;
  logic                  r_core_stall;
  logic                  r_dbg_ack;
  logic [REG_DATA_W-1:0] r_dbg_rdata;

  // Request fields captured at acceptance; later changes on the debug
  // inputs must not disturb the access in flight.
  logic                  r_dbg_we;
  logic [REG_ADDR_W-1:0] r_dbg_addr;
  logic [REG_DATA_W-1:0] r_dbg_wdata;

  logic w_ctr_clr;
  logic w_ctr_inc;
  logic w_at_limit;

  // Counter is held clear while idle and counts busy core cycles in WAIT.
  assign w_ctr_clr = (r_state == ST_IDLE);
  assign w_ctr_inc = (r_state == ST_WAIT) && core_ld_reg;

  regfile_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk        (clk),
    .reset_     (reset_),
    .i_clr      (w_ctr_clr),
    .i_inc      (w_ctr_inc),
    .o_at_limit (w_at_limit)
  );

  // Capture the debug request when it is accepted from IDLE.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && dbg_req) begin
      r_dbg_we    <= dbg_we;
      r_dbg_addr  <= dbg_addr;
      r_dbg_wdata <= dbg_wdata;
    end
  end

  // Arbiter FSM; stall and ack are registered alongside the state so the
  // core and the host never see a combinational path from any input.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state      <= ST_IDLE;
      r_core_stall <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (dbg_req) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A write-free core cycle (or the timeout) lets the stall begin;
          // any in-flight core write still lands during STALL.
          if (!core_ld_reg || w_at_limit) begin
            r_state      <= ST_STALL;
            r_core_stall <= 1'b1;
          end
        end
        ST_STALL: begin
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_state      <= ST_RESP;
          r_core_stall <= 1'b0;
          r_dbg_ack    <= 1'b1;
          if (!r_dbg_we) begin
            r_dbg_rdata <= rf_sr2;
          end
        end
        ST_RESP: begin
          // Ack is held until the host drops its request.
          if (!dbg_req) begin
            r_state   <= ST_IDLE;
            r_dbg_ack <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_core_stall <= 1'b0;
          r_dbg_ack    <= 1'b0;
        end
      endcase
    end
  end

  // Port mux: passthrough everywhere except ACCESS, where the host owns
  // both the write port and the SR2 select and core_* is ignored.
  always_comb begin
    rf_ld_reg  = core_ld_reg;
    rf_dr      = core_dr;
    rf_bus     = core_bus;
    rf_sr2_sel = core_sr2_sel;
    if (r_state == ST_ACCESS) begin
      rf_ld_reg  = r_dbg_we;
      rf_dr      = r_dbg_addr;
      rf_bus     = r_dbg_wdata;
      rf_sr2_sel = r_dbg_addr;
    end
  end

  assign core_stall = r_core_stall;
  assign dbg_ack    = r_dbg_ack;
  assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Bench for regfile_debug_arbiter with a behavioural register file attached.
// Expected debug results go into a scoreboard queue when a request is issued
// and are popped and compared when the acknowledge arrives.
module tb_regfile_debug_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset_;
  logic        core_ld_reg;
  logic [2:0]  core_dr;
  logic [15:0] core_bus;
  logic [2:0]  core_sr2_sel;
  logic        rf_ld_reg;
  logic [2:0]  rf_dr;
  logic [15:0] rf_bus;
  logic [2:0]  rf_sr2_sel;
  logic [15:0] rf_sr2;
  logic        core_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;

  int checks;
  int errors;

  typedef struct {
    bit          we;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  // Behavioural register file: synchronous write, combinational SR2 read.
  logic [15:0] rf_mem [8];
  always @(posedge clk) begin
    if (rf_ld_reg) rf_mem[rf_dr] <= rf_bus;
  end
  assign rf_sr2 = rf_mem[rf_sr2_sel];

  regfile_debug_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk          (clk),
    .reset_       (reset_),
    .core_ld_reg  (core_ld_reg),
    .core_dr      (core_dr),
    .core_bus     (core_bus),
    .core_sr2_sel (core_sr2_sel),
    .rf_ld_reg    (rf_ld_reg),
    .rf_dr        (rf_dr),
    .rf_bus       (rf_bus),
    .rf_sr2_sel   (rf_sr2_sel),
    .rf_sr2       (rf_sr2),
    .core_stall   (core_stall),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_ack      (dbg_ack),
    .dbg_rdata    (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [2:0] addr, input logic [15:0] data);
    core_ld_reg = 1'b1;
    core_dr     = addr;
    core_bus    = data;
    step();
    core_ld_reg = 1'b0;
  endtask

  // Raise a request and record what the host should get back.
  task automatic start_req(input bit we, input logic [2:0] addr,
                           input logic [15:0] wdata, input logic [15:0] expect_data);
    exp_t e;
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
    e.we = we; e.addr = addr; e.data = expect_data;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset_       = 1'b0;
    core_ld_reg  = 1'b1;
    core_dr      = 3'd6;
    core_bus     = 16'hA5A5;
    core_sr2_sel = 3'd2;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 3'd0; dbg_wdata = 16'h0;
    #2;
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", core_stall); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", dbg_ack); end
    checks++; if (dbg_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0000", dbg_rdata); end
    checks++; if (rf_ld_reg !== 1'b1 || rf_dr !== 3'd6 || rf_bus !== 16'hA5A5 || rf_sr2_sel !== 3'd2) begin
      errors++; $display("FAIL reset_passthru got ld=%b dr=%0d bus=%h sel=%0d want 1 6 a5a5 2", rf_ld_reg, rf_dr, rf_bus, rf_sr2_sel);
    end
    step(); step();
    core_ld_reg = 1'b0;
    reset_ = 1'b1;
    step();
  endtask

  task automatic test_write_idle();
    exp_t e;
    start_req(1'b1, 3'd3, 16'hBEEF, 16'hBEEF);      // cycle 0
    step();                                          // cycle 1: WAIT
    dbg_addr = 3'd1; dbg_wdata = 16'h0BAD;           // must not affect the access
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL wr_wait_stall got %b want 0", core_stall); end
    step();                                          // cycle 2: STALL
    checks++; if (core_stall !== 1'b1 || dbg_ack !== 1'b0) begin
      errors++; $display("FAIL wr_stall got stall=%b ack=%b want 1 0", core_stall, dbg_ack);
    end
    step();                                          // cycle 3: ACCESS
    checks++; if (rf_ld_reg !== 1'b1 || rf_dr !== 3'd3 || rf_bus !== 16'hBEEF) begin
      errors++; $display("FAIL wr_access got ld=%b dr=%0d bus=%h want 1 3 beef", rf_ld_reg, rf_dr, rf_bus);
    end
    step();                                          // cycle 4: RESP
    checks++; if (dbg_ack !== 1'b1 || core_stall !== 1'b0) begin
      errors++; $display("FAIL wr_ack got ack=%b stall=%b want 1 0", dbg_ack, core_stall);
    end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL wr_sb got empty want entry");
    end else begin
      e = sb.pop_front();
      checks++; if (rf_mem[e.addr] !== e.data) begin errors++; $display("FAIL wr_mem got %h want %h", rf_mem[e.addr], e.data); end
    end
    dbg_req = 1'b0;
    step();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_drop got %b want 0", dbg_ack); end
  endtask

  task automatic test_read();
    exp_t e;
    core_write(3'd5, 16'h1234);
    core_sr2_sel = 3'd1;
    start_req(1'b0, 3'd5, 16'h0000, 16'h1234);       // cycle 0
    step(); step(); step();                          // cycle 3: ACCESS
    checks++; if (rf_sr2_sel !== 3'd5 || rf_ld_reg !== 1'b0) begin
      errors++; $display("FAIL rd_access got sel=%0d ld=%b want 5 0", rf_sr2_sel, rf_ld_reg);
    end
    step();                                          // cycle 4: RESP
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %b want 1", dbg_ack); end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL rd_sb got empty want entry");
    end else begin
      e = sb.pop_front();
      checks++; if (dbg_rdata !== e.data) begin errors++; $display("FAIL rd_data got %h want %h", dbg_rdata, e.data); end
    end
    dbg_req = 1'b0;
    step(); step();
    checks++; if (dbg_rdata !== 16'h1234 || rf_sr2_sel !== 3'd1) begin
      errors++; $display("FAIL rd_hold got rdata=%h sel=%0d want 1234 1", dbg_rdata, rf_sr2_sel);
    end
  endtask

  task automatic test_core_busy();
    exp_t e;
    int   ack_cyc;
    bit   seen;
    ack_cyc = -1;
    seen    = 1'b0;
    core_ld_reg = 1'b1; core_dr = 3'd7; core_bus = 16'h7000;
    start_req(1'b1, 3'd6, 16'h6666, 16'h6666);       // cycle 0
`ifdef REGFILE_ARB_TIMEOUT_EN
    for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
      step();
      if (c == 5) begin
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL busy_wait5 got %b want 0", core_stall); end
      end
      if (c == 6) begin
        checks++; if (core_stall !== 1'b1 || rf_ld_reg !== 1'b1 || rf_dr !== 3'd7) begin
          errors++; $display("FAIL busy_stall6 got stall=%b ld=%b dr=%0d want 1 1 7", core_stall, rf_ld_reg, rf_dr);
        end
      end
      if (dbg_ack === 1'b1) ack_cyc = c;
      core_bus = core_bus + 16'd1;
    end
    checks++; if (ack_cyc != 8) begin errors++; $display("FAIL busy_ack_cycle got %0d want 8", ack_cyc); end
    core_ld_reg = 1'b0;
`else
    repeat (100) begin
      step();
      if (dbg_ack !== 1'b0 || core_stall !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL busy_starve got ack_or_stall=1 want 0"); end
    core_ld_reg = 1'b0;
    for (int c = 1; c <= 10 && ack_cyc < 0; c++) begin
      step();
      if (dbg_ack === 1'b1) ack_cyc = c;
    end
    checks++; if (ack_cyc != 3) begin errors++; $display("FAIL busy_release got %0d want 3", ack_cyc); end
`endif
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL busy_sb got empty want entry");
    end else begin
      e = sb.pop_front();
      checks++; if (rf_mem[e.addr] !== e.data) begin errors++; $display("FAIL busy_mem got %h want %h", rf_mem[e.addr], e.data); end
    end
    dbg_req = 1'b0;
    step();
  endtask

  task automatic test_collision();
    exp_t e;
    core_write(3'd3, 16'h5555);
    start_req(1'b1, 3'd3, 16'hBEEF, 16'hBEEF);       // cycle 0
    step(); step(); step();                          // cycle 3: ACCESS
    core_ld_reg = 1'b1; core_dr = 3'd3; core_bus = 16'h0001;
    #1;
    checks++; if (rf_ld_reg !== 1'b1 || rf_dr !== 3'd3 || rf_bus !== 16'hBEEF) begin
      errors++; $display("FAIL coll_mux got ld=%b dr=%0d bus=%h want 1 3 beef", rf_ld_reg, rf_dr, rf_bus);
    end
    step();                                          // cycle 4: RESP
    core_ld_reg = 1'b0;
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL coll_ack got %b want 1", dbg_ack); end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL coll_sb got empty want entry");
    end else begin
      e = sb.pop_front();
      checks++; if (rf_mem[e.addr] !== e.data) begin errors++; $display("FAIL coll_mem got %h want %h", rf_mem[e.addr], e.data); end
    end
    dbg_req = 1'b0;
    step();
  endtask

  task automatic test_handshake_hold();
    exp_t e;
    start_req(1'b0, 3'd3, 16'h0000, 16'hBEEF);       // cycle 0
    step(); step(); step(); step();                  // cycle 4: RESP
    checks++; if (dbg_ack !== 1'b1) begin errors++; $display("FAIL hold_ack got %b want 1", dbg_ack); end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL hold_sb got empty want entry");
    end else begin
      e = sb.pop_front();
      checks++; if (dbg_rdata !== e.data) begin errors++; $display("FAIL hold_data got %h want %h", dbg_rdata, e.data); end
    end
    for (int i = 0; i < 5; i++) begin
      dbg_addr = 3'(i); dbg_we = 1'b1;
      step();
      checks++; if (dbg_ack !== 1'b1 || core_stall !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d got ack=%b stall=%b want 1 0", i, dbg_ack, core_stall);
      end
    end
    dbg_req = 1'b0;
    step();
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", dbg_ack); end
  endtask

  task automatic test_reset_midop();
    core_write(3'd4, 16'h4444);
    start_req(1'b1, 3'd4, 16'hDEAD, 16'hDEAD);       // cycle 0
    step(); step();                                  // cycle 2: STALL
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b want 1", core_stall); end
    reset_ = 1'b0;
    #1;
    checks++; if (core_stall !== 1'b0 || dbg_ack !== 1'b0 || dbg_rdata !== 16'h0000) begin
      errors++; $display("FAIL rst_async got stall=%b ack=%b rdata=%h want 0 0 0000", core_stall, dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0;
    sb.delete();
    step(); step();
    reset_ = 1'b1;
    repeat (4) step();
    checks++; if (rf_mem[4] !== 16'h4444) begin errors++; $display("FAIL rst_mem got %h want 4444", rf_mem[4]); end
    checks++; if (dbg_ack !== 1'b0 || core_stall !== 1'b0) begin
      errors++; $display("FAIL rst_idle got ack=%b stall=%b want 0 0", dbg_ack, core_stall);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_idle();
    test_read();
    test_core_busy();
    test_collision();
    test_handshake_hold();
    test_reset_midop();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
